// File: rtl/pulse_spacer.sv
// ============================================================================
// Module      : pulse_spacer
// Description : Source-domain event spacer. Counts incoming single-cycle
//               events as pending work and re-emits each one as a
//               PULSE_CYCLES-wide pulse followed by at least GAP_CYCLES of
//               low time. This lets a slower destination clock see every
//               event. Events that arrive while the queue is full are
//               dropped and flagged by a sticky overflow bit.
//               Optional macro PULSE_SPACER_DROP_CNT_EN adds a saturating
//               16-bit drop counter output (drop_count).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_spacer #(
  parameter int PULSE_CYCLES = 3,
  parameter int GAP_CYCLES   = 3,
  parameter int MAX_PENDING  = 15,
  localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             event_in,
  input  logic             ovf_clr,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
`ifdef PULSE_SPACER_DROP_CNT_EN
  output logic [15:0]      drop_count,
`endif
  output logic             overflow
);

  // Cycle counter must hold the larger of the two phase lengths minus one.
  localparam int C_MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int C_CYC_W   = $clog2(C_MAX_CYC + 1);

  localparam logic [C_CYC_W-1:0] C_PULSE_LOAD = C_CYC_W'(PULSE_CYCLES - 1);
  localparam logic [C_CYC_W-1:0] C_GAP_LOAD   = C_CYC_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   C_MAX_PEND   = CNT_W'(MAX_PENDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [C_CYC_W-1:0]   r_cnt;
  logic [C_CYC_W-1:0]   w_cnt_nxt;
  logic                 r_pulse;
  logic                 w_pulse_nxt;
  logic                 w_take;
  logic [CNT_W-1:0]     r_pending;
  logic [CNT_W-1:0]     w_pending_nxt;
  logic                 r_overflow;
  logic                 w_full;
  logic                 w_drop;

  // State, cycle counter and output pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  // Next-state logic; a "take" consumes one pending event as a pulse starts
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = r_pulse;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending != '0) begin
          w_state_nxt = S_PULSE;
          w_pulse_nxt = 1'b1;
          w_cnt_nxt   = C_PULSE_LOAD;
          w_take      = 1'b1;
        end
      end
      S_PULSE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt = S_GAP;
          w_pulse_nxt = 1'b0;
          w_cnt_nxt   = C_GAP_LOAD;
        end
      end
      S_GAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (r_pending != '0) begin
          w_state_nxt = S_PULSE;
          w_pulse_nxt = 1'b1;
          w_cnt_nxt   = C_PULSE_LOAD;
          w_take      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pulse_nxt = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // An event is only lost when the queue is full and nothing leaves this cycle
  assign w_full = (r_pending == C_MAX_PEND);
  assign w_drop = event_in && !w_take && w_full;

  // Pending count next value: simultaneous event and take cancel out
  always_comb begin
    w_pending_nxt = r_pending;
    if (event_in && !w_take && !w_full) begin
      w_pending_nxt = r_pending + 1'b1;
    end else if (!event_in && w_take) begin
      w_pending_nxt = r_pending - 1'b1;
    end
  end

  // Pending count and sticky overflow; a drop beats a same-edge clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef PULSE_SPACER_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  // Saturating drop counter; a same-edge clear and drop leaves a count of one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (ovf_clr) begin
      r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_count = r_drop_cnt;
`endif

  assign pulse_out = r_pulse;
  assign pending   = r_pending;
  assign overflow  = r_overflow;
  assign busy      = (r_pending != '0) || (r_state != S_IDLE);

endmodule

`default_nettype wire
